ahb_subordinate_mem: RTL and testbench
======================================

Name: ahb_subordinate_mem

Overview:
- Synthesisable AHB subordinate backed by a byte-addressed memory.
- Parametrised successor to the team's testbench-side transfer/config structs: adds a programmable wait-state count, address-window decode with two-cycle ERROR, HSIZE/HWSTRB lane handling, and optional burst-sequence checking.
- Sits behind the interconnect decoder, one instance per HSELx slot; used as the DUT-side target for master-agent tests.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width; legal values 32, 64, 128.
- MEM_BYTES_LOG2, 12, memory size is 2**MEM_BYTES_LOG2 bytes.
- BASE_ADDR, 32'h0000_0000, first byte of the window; must be aligned to the window size.
- MAX_WAIT, 15, maximum programmable wait states; sets counter width to $clog2(MAX_WAIT+1).

Ports:
- hclk  in  1  clock.
- hresetn  in  1  asynchronous active-low reset.
- hselx  in  1  slot select.
- haddr  in  ADDR_WIDTH  address.
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hburst  in  3  burst type.
- hprot  in  4  protection; captured, not acted on.
- hwdata  in  DATA_WIDTH  write data.
- hwstrb  in  DATA_WIDTH/8  write strobes.
- hready  in  1  combined ready.
- cfg_wait_states  in  $clog2(MAX_WAIT+1)  wait cycles per accepted transfer; sampled at address phase.
- hreadyout  out  1  subordinate ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_WIDTH  read data.

Behaviour:
- Reset (async assert, sync deassert via hclk): hreadyout=1, hresp=0, hrdata=0, state=IDLE, wait counter=0.
  - Memory contents are not reset.
  - Reset mid-transfer drops any pending write.
- Address phase is accepted when hselx & hready & htrans[1]. It captures haddr, hwrite, hsize, hburst, and the wait value (clamped to MAX_WAIT).
- IDLE or BUSY with hselx & hready: next cycle gives a zero-wait OKAY and no memory access.
- Error check at acceptance; any one of these raises an error:
  - address outside [BASE_ADDR, BASE_ADDR + 2**MEM_BYTES_LOG2);
  - hsize > log2(DATA_WIDTH/8);
  - address not aligned to 2**hsize.
- States:
  - IDLE: hreadyout=1, hresp=0.
    - Accepted error -> ERR1.
    - Accepted OK with wait=0 -> DATA.
    - Accepted OK with wait>0 -> WAIT, counter loaded with wait-1.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 -> DATA.
  - DATA: hreadyout=1, hresp=0; transfer completes this cycle.
    - New accepted transfer -> per IDLE rules; otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1. Accepts a new transfer like IDLE, else -> IDLE.
- Write commit: on the clock edge ending DATA, using the captured address.
  - A byte is written if it lies in the active lane set for hsize/haddr[log2(DATA_WIDTH/8)-1:0] AND its hwstrb bit is set.
  - Strobes outside the active lanes are ignored.
- Read: hrdata is valid only in the DATA cycle, taken from memory at the captured address with active lanes placed little-endian. All other bytes read 0.
  - hrdata is 0 in every non-DATA cycle.
  - A read immediately following a write to the same address returns the new data, because the write commits before the read's data phase.
- Address phase with hready=0 (another subordinate stalling) is ignored.
- Wrap-around: memory index is (haddr - BASE_ADDR) truncated to MEM_BYTES_LOG2 bits. There is no internal wrap beyond the window, since out-of-window accesses error.

Optional Feature:
- Macro: AHB_SUB_BURST_CHECK_EN.
- Defined:
  - Tracks the expected next address for INCR/INCRx/WRAPx using the captured hburst, hsize, and beat count. WRAPx boundary = beats * 2**hsize.
  - A SEQ whose haddr differs from the expected address, or a SEQ not preceded by NONSEQ/SEQ of the same burst, takes the ERR1/ERR2 path.
  - A SEQ beyond the fixed beat count also errors.
- Undefined: SEQ is treated exactly like NONSEQ, with no burst tracking logic.

Decomposition:
- Shared package additions:
  - ahbSubStateEnum {IDLE_S, WAIT_S, DATA_S, ERR1_S, ERR2_S};
  - function burstBeats(ahbBurstEnum) returning 1/0(undefined)/4/8/16;
  - function laneMask(hsize, addr low bits, DATA_WIDTH/8).
  - Reuse existing ahbBurstEnum, ahbTransferEnum, ahbHsizeEnum, ahbRespEnum.
- One sub-module: ahb_burst_addr_calc (next-address and wrap-boundary arithmetic), instantiated only under AHB_SUB_BURST_CHECK_EN.

Test Plan:
- Reset mid-wait: hresetn low during WAIT -> next cycle hreadyout=1, hresp=0, hrdata=0, and the pending write is not committed.
- Word write then read, wait=0: write 0xDEADBEEF @0x10, then read @0x10 -> single-cycle data phases, hrdata=0xDEADBEEF, hresp=0.
- Byte lanes: write hsize=BYTE @0x13, hwdata=0xAA000000, hwstrb=4'b1111 -> read word @0x10 returns 0xAAADBEEF; only lane 3 is written.
- Wait states: cfg_wait_states=3, read @0x10 -> hreadyout low for exactly 3 cycles, then 1 with data; cfg_wait_states=15 -> 15 low cycles.
- Error: read @BASE_ADDR+0x1000 (MEM_BYTES_LOG2=12) -> cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1. Misaligned word @0x2 and hsize=DOUBLEWORD on DATA_WIDTH=32 give the same response.
- Burst check (macro defined): WRAP4 word from 0x38 with SEQ addresses 0x3C, 0x30, 0x34 -> all OKAY. The same burst with second beat 0x40 -> ERROR on that beat.

Source files
------------

// File: rtl/ahb_subordinate_mem_pkg.sv
// Shared AHB types and helpers for ahb_subordinate_mem and its burst
// address calculator: transfer/burst/size/response encodings, the
// subordinate FSM state type, burst beat counts and byte-lane masks.
package ahb_subordinate_mem_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahbTransferEnum;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } ahbBurstEnum;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } ahbHsizeEnum;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } ahbRespEnum;

  typedef enum logic [2:0] {
    IDLE_S,
    WAIT_S,
    DATA_S,
    ERR1_S,
    ERR2_S
  } ahbSubStateEnum;

  // Widest supported bus is 128 bits, i.e. 16 byte lanes.
  localparam int unsigned MAX_LANES = 16;

  // Fixed beat count of a burst type; 0 means undefined length (INCR).
  function automatic int unsigned burstBeats(input ahbBurstEnum burst);
    case (burst)
      HBURST_SINGLE:                return 1;
      HBURST_INCR:                  return 0;
      HBURST_WRAP4,  HBURST_INCR4:  return 4;
      HBURST_WRAP8,  HBURST_INCR8:  return 8;
      HBURST_WRAP16, HBURST_INCR16: return 16;
      default:                      return 1;
    endcase
  endfunction

  // Byte lanes touched by a transfer of 2**hsize bytes whose address low
  // bits are addr_low, on a bus of 'lanes' bytes (little-endian lanes).
  function automatic logic [MAX_LANES-1:0] laneMask(input logic [2:0]  hsize,
                                                    input logic [3:0]  addr_low,
                                                    input int unsigned lanes);
    int unsigned size_bytes;
    int unsigned start;
    logic [MAX_LANES-1:0] mask;
    size_bytes = 32'd1 << hsize;
    if (size_bytes > lanes) size_bytes = lanes;
    start = 32'(addr_low) & (lanes - 1) & ~(size_bytes - 1);
    mask  = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      mask[i] = (i >= start) && (i < start + size_bytes) && (i < lanes);
    end
    return mask;
  endfunction

endpackage

// File: rtl/ahb_subordinate_mem_burst_addr_calc.sv
// Next-beat address arithmetic for AHB bursts: linear increment for
// SINGLE/INCR/INCRx, and wrap at a (beats * 2**hsize) byte boundary for
// WRAPx. Only instantiated when AHB_SUB_BURST_CHECK_EN is defined.
module ahb_burst_addr_calc
  import ahb_subordinate_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] linear;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  int unsigned           beats;

  // Linear next address, then splice in the wrap window for WRAPx.
  always_comb begin
    incr        = ADDR_WIDTH'(1) << hsize_i;
    linear      = addr_i + incr;
    beats       = burstBeats(ahbBurstEnum'(hburst_i));
    wrap_mask   = (ADDR_WIDTH'(beats) << hsize_i) - ADDR_WIDTH'(1);
    next_addr_o = linear;
    case (ahbBurstEnum'(hburst_i))
      HBURST_WRAP4, HBURST_WRAP8, HBURST_WRAP16:
        next_addr_o = (addr_i & ~wrap_mask) | (linear & wrap_mask);
      default: next_addr_o = linear;
    endcase
  end

endmodule

// File: rtl/ahb_subordinate_mem.sv
// AHB subordinate backed by a byte-addressed memory window with a
// programmable wait-state count, two-cycle ERROR for out-of-window,
// oversize or misaligned accesses, and HSIZE/HWSTRB byte-lane handling.
// Optional feature macro: AHB_SUB_BURST_CHECK_EN (SEQ address/sequence
// checking against the captured burst; when undefined SEQ == NONSEQ).
module ahb_subordinate_mem
  import ahb_subordinate_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           MEM_BYTES_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           MAX_WAIT       = 15
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic                             hselx,
  input  logic [ADDR_WIDTH-1:0]            haddr,
  input  logic [1:0]                       htrans,
  input  logic                             hwrite,
  input  logic [2:0]                       hsize,
  input  logic [2:0]                       hburst,
  input  logic [3:0]                       hprot,
  input  logic [DATA_WIDTH-1:0]            hwdata,
  input  logic [DATA_WIDTH/8-1:0]          hwstrb,
  input  logic                             hready,
  input  logic [$clog2(MAX_WAIT+1)-1:0]    cfg_wait_states,
  output logic                             hreadyout,
  output logic                             hresp,
  output logic [DATA_WIDTH-1:0]            hrdata
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_LOG2 = $clog2(LANES);
  localparam int WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam int MEM_BYTES = 2 ** MEM_BYTES_LOG2;
  localparam logic [2:0] MAX_SIZE = 3'(LANE_LOG2);

  ahbSubStateEnum state_q, state_d;
  logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [MEM_BYTES_LOG2-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [2:0]                size_q, size_d;
  logic [2:0]                burst_q, burst_d;
  logic [3:0]                prot_q, prot_d;

  logic              accept, can_accept;
  logic              in_window, size_err, align_err, burst_err, xfer_err;
  logic [6:0]        align_mask;
  logic [WAIT_W-1:0] wait_sel;

  // Address-phase decode: acceptance, error checks and clamped wait value.
  assign accept     = hselx & hready & htrans[1];
  assign can_accept = (state_q == IDLE_S) || (state_q == DATA_S) || (state_q == ERR2_S);
  assign in_window  = (haddr[ADDR_WIDTH-1:MEM_BYTES_LOG2] == BASE_ADDR[ADDR_WIDTH-1:MEM_BYTES_LOG2]);
  assign size_err   = (hsize > MAX_SIZE);
  assign align_mask = (7'd1 << hsize) - 7'd1;
  assign align_err  = |(haddr[6:0] & align_mask);
  assign xfer_err   = ~in_window | size_err | align_err | burst_err;
  assign wait_sel   = (cfg_wait_states > WAIT_W'(MAX_WAIT)) ? WAIT_W'(MAX_WAIT) : cfg_wait_states;

`ifdef AHB_SUB_BURST_CHECK_EN
  logic                  burst_live_q, burst_live_d;
  logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d, next_addr;
  logic [2:0]            trk_burst_q, trk_burst_d;
  logic [2:0]            trk_size_q, trk_size_d;
  logic [4:0]            beat_cnt_q, beat_cnt_d;
  int unsigned           trk_beats;

  ahb_burst_addr_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_burst_addr_calc (
    .addr_i      (haddr),
    .hsize_i     (hsize),
    .hburst_i    (hburst),
    .next_addr_o (next_addr)
  );

  // A SEQ must continue the live burst at the predicted address and
  // stay within the burst's fixed beat count.
  always_comb begin
    burst_err = 1'b0;
    trk_beats = burstBeats(ahbBurstEnum'(trk_burst_q));
    if (htrans == HTRANS_SEQ) begin
      if (!burst_live_q || (hburst != trk_burst_q) || (hsize != trk_size_q) ||
          (haddr != exp_addr_q)) begin
        burst_err = 1'b1;
      end else if ((trk_beats != 0) && (32'(beat_cnt_q) >= trk_beats)) begin
        burst_err = 1'b1;
      end
    end
  end

  // Burst tracker: NONSEQ opens a burst, good SEQ advances it, IDLE or
  // any erroring transfer closes it; BUSY leaves it untouched.
  always_comb begin
    burst_live_d = burst_live_q;
    exp_addr_d   = exp_addr_q;
    trk_burst_d  = trk_burst_q;
    trk_size_d   = trk_size_q;
    beat_cnt_d   = beat_cnt_q;
    if (can_accept && hselx && hready) begin
      if (htrans == HTRANS_IDLE) begin
        burst_live_d = 1'b0;
      end else if (htrans[1]) begin
        if (xfer_err) begin
          burst_live_d = 1'b0;
        end else begin
          burst_live_d = 1'b1;
          exp_addr_d   = next_addr;
          trk_burst_d  = hburst;
          trk_size_d   = hsize;
          beat_cnt_d   = (htrans == HTRANS_SEQ) ? beat_cnt_q + 5'd1 : 5'd1;
        end
      end
    end
  end

  // Burst tracker registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      burst_live_q <= 1'b0;
      exp_addr_q   <= '0;
      trk_burst_q  <= '0;
      trk_size_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      burst_live_q <= burst_live_d;
      exp_addr_q   <= exp_addr_d;
      trk_burst_q  <= trk_burst_d;
      trk_size_q   <= trk_size_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end
`else
  assign burst_err = 1'b0;
`endif

  // Next-state, address-phase capture and bus response outputs.
  // NOTE: every variable gets a default at the top of a combinational block
  // so that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    burst_d    = burst_q;
    prot_d     = prot_q;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    unique case (state_q)
      IDLE_S: state_d = IDLE_S;
      WAIT_S: begin
        hreadyout = 1'b0;
        if (wait_cnt_q == '0) state_d = DATA_S;
        else                  wait_cnt_d = wait_cnt_q - WAIT_W'(1);
      end
      DATA_S: state_d = IDLE_S;
      ERR1_S: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ERR2_S;
      end
      ERR2_S: begin
        hresp   = HRESP_ERROR;
        state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
    if (can_accept && accept) begin
      addr_d  = haddr[MEM_BYTES_LOG2-1:0] - BASE_ADDR[MEM_BYTES_LOG2-1:0];
      write_d = hwrite;
      size_d  = hsize;
      burst_d = hburst;
      prot_d  = hprot;
      if (xfer_err) begin
        state_d = ERR1_S;
      end else if (wait_sel == '0) begin
        state_d = DATA_S;
      end else begin
        state_d    = WAIT_S;
        wait_cnt_d = wait_sel - WAIT_W'(1);
      end
    end
  end

  // FSM and captured address-phase registers.
  // NOTE: state updates use <= so every register samples the pre-edge
  // values; blocking = stays confined to the combinational blocks.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= IDLE_S;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      burst_q    <= '0;
      prot_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      prot_q     <= prot_d;
    end
  end

  logic [7:0]                          mem_q [MEM_BYTES];
  logic [MAX_LANES-1:0]                lane_mask;
  logic [3:0]                          addr_low;
  logic [MEM_BYTES_LOG2-LANE_LOG2-1:0] word_idx;

  assign addr_low  = 4'(addr_q[LANE_LOG2-1:0]);
  assign word_idx  = addr_q[MEM_BYTES_LOG2-1:LANE_LOG2];
  assign lane_mask = laneMask(size_q, addr_low, LANES);

  // Write commit on the edge that ends the DATA cycle, per enabled lane.
  // NOTE: the storage array is deliberately not reset; it sits outside the
  // async-reset domain so it can map onto RAM.
  always_ff @(posedge hclk) begin
    if ((state_q == DATA_S) && write_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_mask[i] && hwstrb[i]) begin
          mem_q[{word_idx, LANE_LOG2'(i)}] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  // Read data: active lanes only, and only during a read DATA cycle.
  always_comb begin
    hrdata = '0;
    if ((state_q == DATA_S) && !write_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_mask[i]) hrdata[8*i +: 8] = mem_q[{word_idx, LANE_LOG2'(i)}];
      end
    end
  end

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Directed bench for ahb_subordinate_mem (default parameters: 32-bit data,
// 4 KiB window at 0). Table of single transfers plus hand-written
// sequences for reset mid-wait, back-to-back, stalled address phase and
// WRAP4 bursts. Burst expectations follow AHB_SUB_BURST_CHECK_EN.
`timescale 1ns/1ps
module tb_ahb_subordinate_mem;
  import ahb_subordinate_mem_pkg::*;

`ifdef AHB_SUB_BURST_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hselx;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        hready;
  logic [3:0]  cfg_wait_states;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        stall;

  // Single subordinate on the bus: combined ready follows our own ready
  // unless the bench forces another subordinate's stall.
  assign hready = hreadyout & ~stall;

  always #5 hclk = ~hclk;

  ahb_subordinate_mem dut (
    .hclk            (hclk),
    .hresetn         (hresetn),
    .hselx           (hselx),
    .haddr           (haddr),
    .htrans          (htrans),
    .hwrite          (hwrite),
    .hsize           (hsize),
    .hburst          (hburst),
    .hprot           (hprot),
    .hwdata          (hwdata),
    .hwstrb          (hwstrb),
    .hready          (hready),
    .cfg_wait_states (cfg_wait_states),
    .hreadyout       (hreadyout),
    .hresp           (hresp),
    .hrdata          (hrdata)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  waitn;
    logic [31:0] exp_rdata;
    int          exp_low;
    logic        exp_resp;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [31:0] addr, input logic wr,
                     input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [3:0] waitn, input logic [31:0] exp_rdata, input int exp_low,
                     input logic exp_resp, input logic chk_data);
    vec_t v;
    v.name = name; v.addr = addr; v.wr = wr; v.size = size; v.wdata = wdata;
    v.strb = strb; v.waitn = waitn; v.exp_rdata = exp_rdata; v.exp_low = exp_low;
    v.exp_resp = exp_resp; v.chk_data = chk_data;
    vecs.push_back(v);
  endtask

  // One non-pipelined transfer: address phase, then data phase until
  // hreadyout is seen high (bounded), returning what was observed.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [3:0] waitn,
                      output logic [31:0] rdata, output int low,
                      output logic first_resp, output logic last_resp);
    hselx = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = size;
    hburst = HBURST_SINGLE; cfg_wait_states = waitn;
    @(posedge hclk); #1;
    htrans = HTRANS_IDLE; hwdata = wdata; hwstrb = strb;
    low = 0; first_resp = 1'bx; last_resp = 1'bx; rdata = 'x;
    for (int c = 0; c < 40; c++) begin
      @(negedge hclk);
      if (c == 0) first_resp = hresp;
      if (hreadyout) begin
        rdata = hrdata; last_resp = hresp;
        break;
      end
      low++;
      @(posedge hclk); #1;
    end
    @(posedge hclk); #1;
  endtask

  logic [31:0] wrap_addrs [4];
  logic [31:0] rd;
  int          low;
  logic        r0, r1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    hresetn = 1'b0; hselx = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_WORD; hburst = HBURST_SINGLE; hprot = 4'b0011; hwdata = '0;
    hwstrb = '0; cfg_wait_states = '0; stall = 1'b0;

    // Reset state.
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("reset.hreadyout", 32'(hreadyout), 32'd1);
    check("reset.hresp", 32'(hresp), 32'd0);
    check("reset.hrdata", hrdata, 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // name, addr, wr, size, wdata, strb, wait, exp_rdata, exp_low, exp_resp, chk_data
    add("wr_word_10",   32'h10, 1, HSIZE_WORD,  32'hDEADBEEF, 4'hF, 0,  32'h0,        0, 0, 0);
    add("rd_word_10",   32'h10, 0, HSIZE_WORD,  32'h0,        4'h0, 0,  32'hDEADBEEF, 0, 0, 1);
    add("wr_byte_13",   32'h13, 1, HSIZE_BYTE,  32'hAA000000, 4'hF, 0,  32'h0,        0, 0, 0);
    add("rd_after_b13", 32'h10, 0, HSIZE_WORD,  32'h0,        4'h0, 0,  32'hAAADBEEF, 0, 0, 1);
    add("rd_wait3",     32'h10, 0, HSIZE_WORD,  32'h0,        4'h0, 3,  32'hAAADBEEF, 3, 0, 1);
    add("rd_wait15",    32'h10, 0, HSIZE_WORD,  32'h0,        4'h0, 15, 32'hAAADBEEF, 15, 0, 1);
    add("wr_half_strb", 32'h10, 1, HSIZE_HALF,  32'h00001111, 4'hE, 0,  32'h0,        0, 0, 0);
    add("rd_half_strb", 32'h10, 0, HSIZE_WORD,  32'h0,        4'h0, 0,  32'hAAAD11EF, 0, 0, 1);
    add("wr_word_20",   32'h20, 1, HSIZE_WORD,  32'h11223344, 4'hF, 0,  32'h0,        0, 0, 0);
    add("wr_half_22",   32'h22, 1, HSIZE_HALF,  32'hCAFE0000, 4'hF, 0,  32'h0,        0, 0, 0);
    add("wr_b20_nostb", 32'h20, 1, HSIZE_BYTE,  32'h000000FF, 4'h0, 0,  32'h0,        0, 0, 0);
    add("rd_word_20",   32'h20, 0, HSIZE_WORD,  32'h0,        4'h0, 0,  32'hCAFE3344, 0, 0, 1);
    add("rd_half_22",   32'h22, 0, HSIZE_HALF,  32'h0,        4'h0, 0,  32'hCAFE0000, 0, 0, 1);
    add("rd_byte_21",   32'h21, 0, HSIZE_BYTE,  32'h0,        4'h0, 0,  32'h00003300, 0, 0, 1);
    add("wr_word_0",    32'h0,  1, HSIZE_WORD,  32'h01020304, 4'hF, 0,  32'h0,        0, 0, 0);
    add("wr_oow_1000",  32'h1000, 1, HSIZE_WORD, 32'h55555555, 4'hF, 0, 32'h0,        1, 1, 1);
    add("rd_word_0",    32'h0,  0, HSIZE_WORD,  32'h0,        4'h0, 0,  32'h01020304, 0, 0, 1);
    add("rd_oow_1000",  32'h1000, 0, HSIZE_WORD, 32'h0,       4'h0, 0,  32'h0,        1, 1, 1);
    add("rd_misalign2", 32'h2,  0, HSIZE_WORD,  32'h0,        4'h0, 0,  32'h0,        1, 1, 1);
    add("rd_dword",     32'h0,  0, HSIZE_DWORD, 32'h0,        4'h0, 0,  32'h0,        1, 1, 1);
    add("rd_half_11",   32'h11, 0, HSIZE_HALF,  32'h0,        4'h0, 0,  32'h0,        1, 1, 1);
    add("rd_oow_wait5", 32'h1000, 0, HSIZE_WORD, 32'h0,       4'h0, 5,  32'h0,        1, 1, 1);
    add("rd_high",      32'hFFFFFFFC, 0, HSIZE_WORD, 32'h0,   4'h0, 0,  32'h0,        1, 1, 1);
    add("wr_top_ffc",   32'hFFC, 1, HSIZE_WORD, 32'h0BADF00D, 4'hF, 1,  32'h0,        1, 0, 0);
    add("rd_top_ffc",   32'hFFC, 0, HSIZE_WORD, 32'h0,        4'h0, 2,  32'h0BADF00D, 2, 0, 1);

    foreach (vecs[i]) begin
      xfer(vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].wdata, vecs[i].strb,
           vecs[i].waitn, rd, low, r0, r1);
      check($sformatf("%s.low_cycles", vecs[i].name), 32'(low), 32'(vecs[i].exp_low));
      check($sformatf("%s.first_resp", vecs[i].name), 32'(r0), 32'(vecs[i].exp_resp));
      check($sformatf("%s.last_resp", vecs[i].name), 32'(r1), 32'(vecs[i].exp_resp));
      if (vecs[i].chk_data)
        check($sformatf("%s.hrdata", vecs[i].name), rd, vecs[i].exp_rdata);
    end

    // Reset during WAIT drops the pending write.
    xfer(32'h40, 1, HSIZE_WORD, 32'h12345678, 4'hF, 0, rd, low, r0, r1);
    hselx = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h40; hwrite = 1'b1;
    hsize = HSIZE_WORD; cfg_wait_states = 4'd5;
    @(posedge hclk); #1;
    htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
    @(negedge hclk);
    check("midwait.in_wait", 32'(hreadyout), 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b0;
    @(negedge hclk);
    check("midwait.hreadyout", 32'(hreadyout), 32'd1);
    check("midwait.hresp", 32'(hresp), 32'd0);
    check("midwait.hrdata", hrdata, 32'd0);
    repeat (6) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(posedge hclk); #1;
    xfer(32'h40, 0, HSIZE_WORD, 32'h0, 4'h0, 0, rd, low, r0, r1);
    check("midwait.no_commit", rd, 32'h12345678);

    // Back-to-back write then read of the same word.
    hselx = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h50; hwrite = 1'b1;
    hsize = HSIZE_WORD; cfg_wait_states = 4'd0;
    @(posedge hclk); #1;
    hwdata = 32'hA5A55A5A; hwstrb = 4'hF; hwrite = 1'b0;
    @(negedge hclk);
    check("b2b.wr_ready", 32'(hreadyout), 32'd1);
    @(posedge hclk); #1;
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    check("b2b.rd_ready", 32'(hreadyout), 32'd1);
    check("b2b.rd_data", hrdata, 32'hA5A55A5A);
    @(posedge hclk); #1;

    // Address phase with hready low is ignored.
    stall = 1'b1; hselx = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h10;
    hwrite = 1'b0; cfg_wait_states = 4'd3;
    @(posedge hclk); #1;
    stall = 1'b0; htrans = HTRANS_IDLE;
    @(negedge hclk);
    check("stall.hreadyout", 32'(hreadyout), 32'd1);
    check("stall.hrdata", hrdata, 32'd0);
    @(posedge hclk); #1;

    // BUSY gives a zero-wait OKAY with no data.
    htrans = HTRANS_BUSY; haddr = 32'h1000;
    @(posedge hclk); #1;
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    check("busy.hreadyout", 32'(hreadyout), 32'd1);
    check("busy.hresp", 32'(hresp), 32'd0);
    check("busy.hrdata", hrdata, 32'd0);
    @(posedge hclk); #1;

    // WRAP4 word burst from 0x38, pipelined, all OKAY in either build.
    wrap_addrs[0] = 32'h38; wrap_addrs[1] = 32'h3C; wrap_addrs[2] = 32'h30; wrap_addrs[3] = 32'h34;
    hselx = 1'b1; hwrite = 1'b1; hsize = HSIZE_WORD; hburst = HBURST_WRAP4;
    cfg_wait_states = 4'd0; hwstrb = 4'hF;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        htrans = (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        haddr  = wrap_addrs[k];
      end else begin
        htrans = HTRANS_IDLE;
      end
      if (k > 0) hwdata = 32'hB0000000 + 32'(k - 1);
      if (k > 0) begin
        @(negedge hclk);
        check($sformatf("wrap4_ok.beat%0d", k - 1), {30'd0, hreadyout, hresp}, 32'b10);
      end
      @(posedge hclk); #1;
    end
    xfer(32'h30, 0, HSIZE_WORD, 32'h0, 4'h0, 0, rd, low, r0, r1);
    check("wrap4_ok.mem_30", rd, 32'hB0000002);

    // Same burst with a wrong second-beat address.
    hselx = 1'b1; hwrite = 1'b1; hsize = HSIZE_WORD; hburst = HBURST_WRAP4;
    htrans = HTRANS_NONSEQ; haddr = 32'h38;
    @(posedge hclk); #1;
    htrans = HTRANS_SEQ; haddr = 32'h40; hwdata = 32'hC0000000;
    @(negedge hclk);
    check("wrap4_bad.beat0", {30'd0, hreadyout, hresp}, 32'b10);
    @(posedge hclk); #1;
    htrans = HTRANS_IDLE; hwdata = 32'hC0000001;
    @(negedge hclk);
    check("wrap4_bad.beat1_c1", {30'd0, hreadyout, hresp}, BCHK ? 32'b01 : 32'b10);
    @(posedge hclk); #1;
    @(negedge hclk);
    check("wrap4_bad.beat1_c2", {30'd0, hreadyout, hresp}, BCHK ? 32'b11 : 32'b10);
    @(posedge hclk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
